// File: rtl/tree_filler_pkg.sv
// Shared sizing for the sorter-tree refill path; SORTER_STAGE_TREE imports the same constants.
package tree_filler_pkg;
  localparam int TF_W_LOG   = 7;
  localparam int TF_Q_SIZE  = 2;
  localparam int TF_BUF_LOG = 1;
  localparam int TF_DATW    = 64;
  localparam int TF_KEYW    = 32;
  localparam int TF_RECW    = TF_DATW;

  typedef logic [TF_RECW-1:0] record_t;
endpackage

// File: rtl/tree_filler_dfifo.sv
// Small in-order FIFO (DFIFO) used as the leaf-way request queue.
module tree_filler_dfifo #(
  parameter int FIFO_SIZE = 2,
  parameter int WIDTH     = 7
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             i_enq,
  input  logic [WIDTH-1:0] i_enq_data,
  input  logic             i_deq,
  output logic [WIDTH-1:0] o_head,
  output logic             o_emp,
  output logic             o_full,
  output logic             o_ovf
);
  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam logic [FIFO_SIZE:0] CNT_FULL = (FIFO_SIZE+1)'(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [FIFO_SIZE-1:0] r_wp;
  logic [FIFO_SIZE-1:0] r_rp;
  logic [FIFO_SIZE:0]   r_cnt;
  logic                 w_push;
  logic                 w_pop;

  assign o_emp  = (r_cnt == '0);
  assign o_full = (r_cnt == CNT_FULL);
  assign o_head = r_mem[r_rp];
  assign w_pop  = i_deq && !o_emp;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push = i_enq && (!o_full || w_pop);
  assign o_ovf  = i_enq && !w_push;

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= i_enq_data;
  end
endmodule

// File: rtl/tree_filler.sv
// Responder for sorter-tree refill requests: queues way requests in order and
// answers each from a per-way record buffer, one record per cycle, 1-cycle latency.
module tree_filler import tree_filler_pkg::*; #(
  parameter int W_LOG   = TF_W_LOG,
  parameter int Q_SIZE  = TF_Q_SIZE,
  parameter int BUF_LOG = TF_BUF_LOG,
  parameter int DATW    = TF_DATW,
  parameter int KEYW    = TF_KEYW
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic [W_LOG-1:0]       i_request,
  input  logic                   i_request_valid,
  output logic                   QUEUE_FULL,
  input  logic [DATW-1:0]        din,
  input  logic                   dinen,
  input  logic [W_LOG-1:0]       din_idx,
  output logic [(1<<W_LOG)-1:0]  way_nfull,
  output logic [DATW-1:0]        dot,
  output logic                   doten,
  output logic [W_LOG-1:0]       dot_idx,
  output logic                   err
);
  localparam int NW     = 1 << W_LOG;
  localparam int BDEPTH = 1 << BUF_LOG;
  localparam logic [BUF_LOG:0] BUF_FULL = (BUF_LOG+1)'(BDEPTH);

  logic [W_LOG-1:0]   w_head;
  logic               w_q_emp;
  logic               w_q_full;
  logic               w_q_ovf;
  logic               w_serve;
  logic               w_din_full;
  logic               w_wr_ok;
  logic               w_wr_drop;
  logic [NW-1:0]      w_inc;
  logic [NW-1:0]      w_dec;
  logic [DATW-1:0]    w_rd;

  logic [BUF_LOG-1:0] r_wp  [NW];
  logic [BUF_LOG-1:0] r_rp  [NW];
  logic [BUF_LOG:0]   r_cnt [NW];
  logic [DATW-1:0]    r_mem [1 << (W_LOG + BUF_LOG)];

  logic [KEYW-1:0]      r_key_p1;
  logic [DATW-KEYW-1:0] r_pay_p1;
  logic [W_LOG-1:0]     r_idx_p1;
  logic                 r_vld_p1;
  logic                 r_err;

  tree_filler_dfifo #(
    .FIFO_SIZE (Q_SIZE),
    .WIDTH     (W_LOG)
  ) request_queue (
    .CLK        (CLK),
    .RST_X      (RST_X),
    .i_enq      (i_request_valid),
    .i_enq_data (i_request),
    .i_deq      (w_serve),
    .o_head     (w_head),
    .o_emp      (w_q_emp),
    .o_full     (w_q_full),
    .o_ovf      (w_q_ovf)
  );

  // No write-to-read bypass: an empty head way blocks until its record has landed.
  assign w_serve    = !w_q_emp && (r_cnt[w_head] != '0);
  assign w_din_full = (r_cnt[din_idx] == BUF_FULL);
  assign w_wr_ok    = dinen && (!w_din_full || (w_serve && (w_head == din_idx)));
  assign w_wr_drop  = dinen && !w_wr_ok;
  assign w_rd       = r_mem[{w_head, r_rp[w_head]}];

  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    way_nfull = '0;
    for (int i = 0; i < NW; i++) begin
      w_inc[i]     = w_wr_ok && (din_idx == W_LOG'(i));
      w_dec[i]     = w_serve && (w_head == W_LOG'(i));
      way_nfull[i] = (r_cnt[i] != BUF_FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      for (int i = 0; i < NW; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      if (w_wr_ok) r_wp[din_idx] <= r_wp[din_idx] + 1'b1;
      if (w_serve) r_rp[w_head]  <= r_rp[w_head] + 1'b1;
      for (int i = 0; i < NW; i++) begin
        if (w_inc[i] != w_dec[i])
          r_cnt[i] <= w_inc[i] ? r_cnt[i] + 1'b1 : r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_ok) r_mem[{din_idx, r_wp[din_idx]}] <= din;
  end

  // Stage p1: served record, tagged with its way.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_vld_p1 <= 1'b0;
      r_idx_p1 <= '0;
      r_key_p1 <= '0;
      r_pay_p1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_vld_p1 <= w_serve;
      if (w_serve) begin
        r_idx_p1 <= w_head;
        r_key_p1 <= w_rd[KEYW-1:0];
        r_pay_p1 <= w_rd[DATW-1:KEYW];
      end
      r_err <= r_err | w_wr_drop | w_q_ovf;
    end
  end

  assign QUEUE_FULL = w_q_full;
  assign dot        = {r_pay_p1, r_key_p1};
  assign doten      = r_vld_p1;
  assign dot_idx    = r_idx_p1;
  assign err        = r_err;
endmodule

// File: tb/tb_tree_filler.sv
// Scoreboard bench for tree_filler with 8 ways, 4-entry request queue, 2-deep way buffers.
module tb_tree_filler;
  localparam int WL = 3;
  localparam int QS = 2;
  localparam int BL = 1;
  localparam int DW = 64;
  localparam int KW = 32;
  localparam int NW = 1 << WL;

  typedef struct packed {
    logic [WL-1:0] idx;
    logic [DW-1:0] rec;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic [WL-1:0] i_request = '0;
  logic          i_request_valid = 1'b0;
  logic          QUEUE_FULL;
  logic [DW-1:0] din = '0;
  logic          dinen = 1'b0;
  logic [WL-1:0] din_idx = '0;
  logic [NW-1:0] way_nfull;
  logic [DW-1:0] dot;
  logic          doten;
  logic [WL-1:0] dot_idx;
  logic          err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  tree_filler #(
    .W_LOG(WL), .Q_SIZE(QS), .BUF_LOG(BL), .DATW(DW), .KEYW(KW)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .i_request(i_request), .i_request_valid(i_request_valid),
    .QUEUE_FULL(QUEUE_FULL), .din(din), .dinen(dinen), .din_idx(din_idx),
    .way_nfull(way_nfull), .dot(dot), .doten(doten), .dot_idx(dot_idx), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] mkrec(input int key);
    return {32'(key * 7 + 32'h100), 32'(key)};
  endfunction

  function automatic exp_t mkexp(input int way, input int key);
    exp_t e;
    e.idx = WL'(way);
    e.rec = mkrec(key);
    return e;
  endfunction

  // Every emitted record must match the oldest outstanding expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (doten === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_dot: got idx=%0d rec=%h, required no output", dot_idx, dot);
      end else begin
        e = sb.pop_front();
        if (dot !== e.rec || dot_idx !== e.idx)
          $display("FAIL dot_data: got idx=%0d rec=%h, required idx=%0d rec=%h",
                   dot_idx, dot, e.idx, e.rec);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    i_request_valid = 1'b0;
    dinen = 1'b0;
  endtask

  task automatic write_way(input int way, input int key);
    dinen = 1'b1;
    din_idx = WL'(way);
    din = mkrec(key);
    step();
    dinen = 1'b0;
  endtask

  task automatic request_way(input int way);
    i_request_valid = 1'b1;
    i_request = WL'(way);
    step();
    i_request_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RST_X = 1'b0;
    step();
    step();
    RST_X = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    RST_X = 1'b0;
    step();
    step();
    n_checks++; if (doten !== 1'b0) $display("FAIL rst_doten: got %b required 0", doten); else n_pass++;
    n_checks++; if (dot !== '0) $display("FAIL rst_dot: got %h required 0", dot); else n_pass++;
    n_checks++; if (dot_idx !== '0) $display("FAIL rst_dot_idx: got %0d required 0", dot_idx); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b required 0", err); else n_pass++;
    n_checks++; if (QUEUE_FULL !== 1'b0) $display("FAIL rst_qfull: got %b required 0", QUEUE_FULL); else n_pass++;
    n_checks++; if (way_nfull !== 8'hFF) $display("FAIL rst_nfull: got %h required ff", way_nfull); else n_pass++;
    RST_X = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NW; i++) write_way(i, i + 1);
    n_checks++; if (way_nfull !== 8'hFF) $display("FAIL b2b_nfull: got %h required ff", way_nfull); else n_pass++;
    for (int i = 0; i < NW; i++) begin
      sb.push_back(mkexp(i, i + 1));
      i_request_valid = 1'b1;
      i_request = WL'(i);
      step();
      if (i > 0) begin
        n_checks++; if (doten !== 1'b1) $display("FAIL b2b_doten_%0d: got %b required 1", i, doten); else n_pass++;
      end
    end
    i_request_valid = 1'b0;
    step();
    n_checks++; if (doten !== 1'b1) $display("FAIL b2b_doten_last: got %b required 1", doten); else n_pass++;
    step();
    n_checks++; if (doten !== 1'b0) $display("FAIL b2b_doten_end: got %b required 0", doten); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL b2b_err: got %b required 0", err); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL b2b_pending: got %0d required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_hol_block();
    write_way(1, 77);
    sb.push_back(mkexp(5, 42));
    request_way(5);
    sb.push_back(mkexp(1, 77));
    request_way(1);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (doten !== 1'b0) $display("FAIL hol_blocked_%0d: got %b required 0", k, doten); else n_pass++;
      step();
    end
    write_way(5, 42);
    n_checks++; if (doten !== 1'b0) $display("FAIL hol_write_edge: got %b required 0", doten); else n_pass++;
    step();
    n_checks++; if (doten !== 1'b1 || dot_idx !== 3'd5) $display("FAIL hol_first: got en=%b idx=%0d required en=1 idx=5", doten, dot_idx); else n_pass++;
    step();
    n_checks++; if (doten !== 1'b1 || dot_idx !== 3'd1) $display("FAIL hol_second: got en=%b idx=%0d required en=1 idx=1", doten, dot_idx); else n_pass++;
    step();
    n_checks++; if (doten !== 1'b0) $display("FAIL hol_done: got %b required 0", doten); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL hol_pending: got %0d required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_way_full();
    write_way(2, 10);
    write_way(2, 11);
    n_checks++; if (way_nfull[2] !== 1'b0) $display("FAIL wf_nfull2: got %b required 0", way_nfull[2]); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL wf_err_before: got %b required 0", err); else n_pass++;
    write_way(2, 12);
    n_checks++; if (err !== 1'b1) $display("FAIL wf_err_drop: got %b required 1", err); else n_pass++;
    n_checks++; if (way_nfull[2] !== 1'b0) $display("FAIL wf_nfull2_drop: got %b required 0", way_nfull[2]); else n_pass++;
    sb.push_back(mkexp(2, 10));
    request_way(2);
    sb.push_back(mkexp(2, 11));
    request_way(2);
    step();
    step();
    n_checks++; if (way_nfull[2] !== 1'b1) $display("FAIL wf_nfull2_drained: got %b required 1", way_nfull[2]); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL wf_pending: got %0d required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_queue_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      request_way(4);
      if (k == 2) begin
        n_checks++; if (QUEUE_FULL !== 1'b0) $display("FAIL qf_three: got %b required 0", QUEUE_FULL); else n_pass++;
      end
    end
    n_checks++; if (QUEUE_FULL !== 1'b1) $display("FAIL qf_full: got %b required 1", QUEUE_FULL); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL qf_err_full: got %b required 0", err); else n_pass++;
    sb.push_back(mkexp(4, 50));
    write_way(4, 50);
    n_checks++; if (QUEUE_FULL !== 1'b1) $display("FAIL qf_before_serve: got %b required 1", QUEUE_FULL); else n_pass++;
    request_way(6);
    n_checks++; if (QUEUE_FULL !== 1'b1) $display("FAIL qf_push_pop: got %b required 1", QUEUE_FULL); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL qf_push_pop_err: got %b required 0", err); else n_pass++;
    n_checks++; if (doten !== 1'b1) $display("FAIL qf_served: got %b required 1", doten); else n_pass++;
    request_way(6);
    n_checks++; if (err !== 1'b1) $display("FAIL qf_overflow_err: got %b required 1", err); else n_pass++;
    n_checks++; if (QUEUE_FULL !== 1'b1) $display("FAIL qf_overflow_full: got %b required 1", QUEUE_FULL); else n_pass++;
    step();
    n_checks++; if (sb.size() != 0) $display("FAIL qf_pending: got %0d required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    write_way(3, 30);
    sb.push_back(mkexp(3, 30));
    request_way(3);
    write_way(3, 99);
    n_checks++; if (doten !== 1'b1) $display("FAIL sc_served: got %b required 1", doten); else n_pass++;
    n_checks++; if (way_nfull[3] !== 1'b1) $display("FAIL sc_nfull_one: got %b required 1", way_nfull[3]); else n_pass++;
    write_way(3, 100);
    n_checks++; if (way_nfull[3] !== 1'b0) $display("FAIL sc_nfull_two: got %b required 0", way_nfull[3]); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL sc_err: got %b required 0", err); else n_pass++;
    sb.push_back(mkexp(3, 99));
    request_way(3);
    sb.push_back(mkexp(3, 100));
    request_way(3);
    step();
    step();
    n_checks++; if (sb.size() != 0) $display("FAIL sc_pending: got %0d required 0", sb.size()); else n_pass++;
    n_checks++; if (way_nfull[3] !== 1'b1) $display("FAIL sc_nfull_end: got %b required 1", way_nfull[3]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) request_way(0);
    for (int w = 1; w < NW; w++) begin
      write_way(w, 200 + w);
      write_way(w, 300 + w);
    end
    write_way(1, 400);
    n_checks++; if (way_nfull !== 8'h01) $display("FAIL rm_nfull_pre: got %h required 01", way_nfull); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL rm_err_pre: got %b required 1", err); else n_pass++;
    RST_X = 1'b0;
    step();
    RST_X = 1'b1;
    n_checks++; if (doten !== 1'b0) $display("FAIL rm_doten: got %b required 0", doten); else n_pass++;
    n_checks++; if (QUEUE_FULL !== 1'b0) $display("FAIL rm_qfull: got %b required 0", QUEUE_FULL); else n_pass++;
    n_checks++; if (way_nfull !== 8'hFF) $display("FAIL rm_nfull: got %h required ff", way_nfull); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rm_err: got %b required 0", err); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (doten !== 1'b0) $display("FAIL rm_quiet_%0d: got %b required 0", k, doten); else n_pass++;
    end
    write_way(1, 55);
    sb.push_back(mkexp(1, 55));
    request_way(1);
    step();
    step();
    n_checks++; if (sb.size() != 0) $display("FAIL rm_pending: got %0d required 0", sb.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hol_block();
    test_way_full();
    test_queue_full();
    test_same_cycle();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
